// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with checkpoint and restore.
//
// The stack is a circular buffer. When it is full, a push overwrites the oldest
// entry; the push is never dropped. Each entry holds a recursion counter, so a
// call that pushes the same return address as the current TOS reuses that slot.
// ckpt_o carries a snapshot of the stack with every prediction. After a
// mispredict, the backend sends that snapshot back on restore_ckpt_i. The
// restore undoes wrong-path pushes and pops, and it rewrites the TOS entry in
// case a wrong-path push overwrote it.
//
// Ports
//   clk            clock
//   rst            synchronous reset, active-high
//   push_i         call predicted; push target_i
//   pop_i          return predicted; pop TOS
//   target_i       return address to push
//   target_o       TOS address (prediction for a return)
//   valid_o        stack non-empty
//   ckpt_o         {tos_ptr, occ, tos_cnt, tos_addr} of the current state
//   restore_i      mispredict recovery; load restore_ckpt_i
//   restore_ckpt_i snapshot previously taken from ckpt_o
module ras_ckpt #(
   parameter int  STACK_DEPTH = 8,
   parameter int  ADDR_W      = 30,
   parameter int  CNT_W       = 2,
   localparam int PTR_W       = $clog2(STACK_DEPTH),
   localparam int OCC_W       = $clog2(STACK_DEPTH + 1),
   localparam int CKPT_W      = PTR_W + OCC_W + CNT_W + ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] target_o,
   output logic              valid_o,
   output logic [CKPT_W-1:0] ckpt_o,
   input  logic              restore_i,
   input  logic [CKPT_W-1:0] restore_ckpt_i
);

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [ADDR_W-1:0] addr [STACK_DEPTH];
   logic [CNT_W-1:0]  cnt  [STACK_DEPTH];
   logic [PTR_W-1:0]  tos_ptr;
   logic [OCC_W-1:0]  occ;

   logic [ADDR_W-1:0] tos_addr;
   logic [CNT_W-1:0]  tos_cnt;
   logic              empty;
   logic              full;
   logic              rec_hit;

   logic [PTR_W-1:0]  snap_ptr;
   logic [OCC_W-1:0]  snap_occ;
   logic [CNT_W-1:0]  snap_cnt;
   logic [ADDR_W-1:0] snap_addr;

   logic [PTR_W-1:0]  nxt_ptr;
   logic [OCC_W-1:0]  nxt_occ;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] wr_addr;
   logic [CNT_W-1:0]  wr_cnt;

   assign tos_addr = addr[tos_ptr];
   assign tos_cnt  = cnt[tos_ptr];
   assign empty    = (occ == '0);
   assign full     = (occ == OCC_FULL);
   assign rec_hit  = !empty && (target_i == tos_addr) && (tos_cnt != CNT_MAX);

   assign {snap_ptr, snap_occ, snap_cnt, snap_addr} = restore_ckpt_i;

   assign target_o = tos_addr;
   assign valid_o  = !empty;
   assign ckpt_o   = {tos_ptr, occ, tos_cnt, tos_addr};

   // Next-state selection. Each operation changes at most one entry, so the
   // entry update is a single write port: wr_idx, wr_addr and wr_cnt.
   // A push and pop in the same cycle on an empty stack falls through to the
   // push-only branch.
   always_comb begin
      nxt_ptr = tos_ptr;
      nxt_occ = occ;
      wr_en   = 1'b0;
      wr_idx  = tos_ptr;
      wr_addr = tos_addr;
      wr_cnt  = tos_cnt;
      if (restore_i) begin
         nxt_ptr = snap_ptr;
         nxt_occ = snap_occ;
         wr_en   = 1'b1;
         wr_idx  = snap_ptr;
         wr_addr = snap_addr;
         wr_cnt  = snap_cnt;
      end else if (push_i && pop_i && !empty) begin
         wr_en   = 1'b1;
         wr_addr = target_i;
         wr_cnt  = '0;
      end else if (push_i) begin
         if (rec_hit) begin
            wr_en  = 1'b1;
            wr_cnt = tos_cnt + CNT_W'(1);
         end else begin
            nxt_ptr = tos_ptr + PTR_W'(1);
            nxt_occ = full ? occ : occ + OCC_W'(1);
            wr_en   = 1'b1;
            wr_idx  = tos_ptr + PTR_W'(1);
            wr_addr = target_i;
            wr_cnt  = '0;
         end
      end else if (pop_i && !empty) begin
         if (tos_cnt != '0) begin
            wr_en  = 1'b1;
            wr_cnt = tos_cnt - CNT_W'(1);
         end else begin
            nxt_ptr = tos_ptr - PTR_W'(1);
            nxt_occ = occ - OCC_W'(1);
         end
      end
   end

   // State registers and entry storage. Reset clears every entry, so
   // target_o and ckpt_o read as zero right after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tos_ptr <= '0;
         occ     <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            addr[i] <= '0;
            cnt[i]  <= '0;
         end
      end else begin
         tos_ptr <= nxt_ptr;
         occ     <= nxt_occ;
         if (wr_en) begin
            addr[wr_idx] <= wr_addr;
            cnt[wr_idx]  <= wr_cnt;
         end
      end
   end

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: self-checking bench for ras_ckpt (DEPTH=8, ADDR_W=30, CNT_W=2).
// Directed table vectors, hand-written multi-cycle sequences and a randomized
// phase compared against a behavioural stack model.
module tb_ras_ckpt;

   localparam int DEPTH  = 8;
   localparam int AW     = 30;
   localparam int CW     = 2;
   localparam int PW     = 3;
   localparam int OW     = 4;
   localparam int KW     = PW + OW + CW + AW;
   localparam int CNTMAX = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          push_i = 1'b0;
   logic          pop_i = 1'b0;
   logic [AW-1:0] target_i = '0;
   logic [AW-1:0] target_o;
   logic          valid_o;
   logic [KW-1:0] ckpt_o;
   logic          restore_i = 1'b0;
   logic [KW-1:0] restore_ckpt_i = '0;

   int checks = 0;
   int errors = 0;

   ras_ckpt #(.STACK_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .push_i(push_i), .pop_i(pop_i),
      .target_i(target_i), .target_o(target_o), .valid_o(valid_o),
      .ckpt_o(ckpt_o), .restore_i(restore_i), .restore_ckpt_i(restore_ckpt_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          push;
      logic          pop;
      logic [AW-1:0] tgt;
      logic [AW-1:0] exp_tgt;
      logic          exp_valid;
      int            exp_ptr;
      int            exp_occ;
      int            exp_cnt;
   } vec_t;

   function automatic logic [KW-1:0] mk_ckpt(int p, int o, int c, logic [AW-1:0] a);
      return {PW'(p), OW'(o), CW'(c), a};
   endfunction

   // Drive one cycle of inputs, then release them 1 ns after the edge.
   task automatic applyStimulus(input logic r, input logic pu, input logic po,
                                input logic rs, input logic [AW-1:0] t,
                                input logic [KW-1:0] ck);
      rst = r; push_i = pu; pop_i = po; restore_i = rs;
      target_i = t; restore_ckpt_i = ck;
      @(posedge clk);
      #1;
      rst = 1'b0; push_i = 1'b0; pop_i = 1'b0; restore_i = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [AW-1:0] et,
                              input logic ev, input logic [KW-1:0] ek);
      checks++;
      if (target_o !== et) begin
         errors++;
         $display("[TB] FAIL %s target_o got %h exp %h", name, target_o, et);
      end
      checks++;
      if (valid_o !== ev) begin
         errors++;
         $display("[TB] FAIL %s valid_o got %b exp %b", name, valid_o, ev);
      end
      checks++;
      if (ckpt_o !== ek) begin
         errors++;
         $display("[TB] FAIL %s ckpt_o got %h exp %h", name, ckpt_o, ek);
      end
   endtask

   // Behavioural reference model: slot contents, TOS index and live count.
   int            m_addr [DEPTH];
   int            m_cnt  [DEPTH];
   int            m_ptr;
   int            m_occ;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_addr[i] = 0;
         m_cnt[i]  = 0;
      end
      m_ptr = 0;
      m_occ = 0;
   endfunction

   function automatic void model_step(bit r, bit pu, bit po, bit rs, int t,
                                      logic [KW-1:0] ck);
      if (r) begin
         model_reset();
      end else if (rs) begin
         m_ptr = int'(ck[KW-1 -: PW]);
         m_occ = int'(ck[KW-PW-1 -: OW]);
         m_cnt[m_ptr]  = int'(ck[AW+CW-1 -: CW]);
         m_addr[m_ptr] = int'(ck[AW-1:0]);
      end else if (pu && po && m_occ > 0) begin
         m_addr[m_ptr] = t;
         m_cnt[m_ptr]  = 0;
      end else if (pu) begin
         if (m_occ > 0 && m_addr[m_ptr] == t && m_cnt[m_ptr] < CNTMAX) begin
            m_cnt[m_ptr] += 1;
         end else begin
            m_ptr = (m_ptr + 1) % DEPTH;
            m_addr[m_ptr] = t;
            m_cnt[m_ptr]  = 0;
            m_occ = (m_occ + 1 > DEPTH) ? DEPTH : m_occ + 1;
         end
      end else if (po && m_occ > 0) begin
         if (m_cnt[m_ptr] > 0) m_cnt[m_ptr] -= 1;
         else begin
            m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
            m_occ -= 1;
         end
      end
   endfunction

   function automatic logic [KW-1:0] model_ckpt();
      return mk_ckpt(m_ptr, m_occ, m_cnt[m_ptr], AW'(m_addr[m_ptr]));
   endfunction

   vec_t          vecs [22];
   logic [KW-1:0] snap;
   logic [KW-1:0] snaps [$];

   initial begin
      // Directed table: basic push/pop, recursion counter, push+pop replace.
      //              rst  push pop  tgt   exp  v  ptr occ cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 30'd0, 30'd0, 1'b0, 0, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 30'd1, 30'd1, 1'b1, 1, 1, 0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 30'd2, 30'd2, 1'b1, 2, 2, 0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 30'd3, 30'd3, 1'b1, 3, 3, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd2, 1'b1, 2, 2, 0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd1, 1'b1, 1, 1, 0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd0, 1'b0, 0, 0, 0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd0, 1'b0, 0, 0, 0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 30'd5, 30'd5, 1'b1, 1, 1, 0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 30'd5, 30'd5, 1'b1, 1, 1, 1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 30'd5, 30'd5, 1'b1, 1, 1, 2};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd5, 1'b1, 1, 1, 1};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd5, 1'b1, 1, 1, 0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd0, 1'b0, 0, 0, 0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 30'd3, 30'd3, 1'b1, 1, 1, 0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 30'd7, 30'd7, 1'b1, 2, 2, 0};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 30'd9, 30'd9, 1'b1, 2, 2, 0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 30'd0, 30'd3, 1'b1, 1, 1, 0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 30'd3, 30'd3, 1'b1, 1, 1, 1};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 30'd3, 30'd3, 1'b1, 1, 1, 2};
      vecs[20] = '{1'b0, 1'b1, 1'b0, 30'd3, 30'd3, 1'b1, 1, 1, 3};
      vecs[21] = '{1'b0, 1'b1, 1'b0, 30'd3, 30'd3, 1'b1, 2, 2, 0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].push, vecs[i].pop, 1'b0, vecs[i].tgt, '0);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_tgt, vecs[i].exp_valid,
                     mk_ckpt(vecs[i].exp_ptr, vecs[i].exp_occ, vecs[i].exp_cnt,
                             vecs[i].exp_tgt));
      end

      // Overflow: ten pushes into eight slots, oldest two are lost.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, AW'(100 + i), '0);
         checkOutput($sformatf("ovf_push%0d", i), AW'(100 + i), 1'b1,
                     mk_ckpt((i + 1) % DEPTH, (i + 1 > DEPTH) ? DEPTH : i + 1, 0,
                             AW'(100 + i)));
      end
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
         if (k < 8)
            checkOutput($sformatf("ovf_pop%0d", k), AW'(109 - k), 1'b1,
                        mk_ckpt((10 - k) % DEPTH, 8 - k, 0, AW'(109 - k)));
      end
      checks++;
      if (valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_empty valid_o got %b exp 0", valid_o);
      end

      // Checkpoint and restore after wrong-path pop and pushes; restore wins
      // over a simultaneous push and pop.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 30'd11, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 30'd12, '0);
      snap = mk_ckpt(2, 2, 0, 30'd12);
      checkOutput("ckpt_take", 30'd12, 1'b1, snap);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 30'd21, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 30'd22, '0);
      checkOutput("wrong_path", 30'd22, 1'b1, mk_ckpt(3, 3, 0, 30'd22));
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 30'd33, snap);
      checkOutput("restore", 30'd12, 1'b1, snap);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("restore_pop", 30'd11, 1'b1, mk_ckpt(1, 1, 0, 30'd11));

      // Reset beats a simultaneous push.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 30'd44, '0);
      checkOutput("rst_push", '0, 1'b0, '0);

      // Randomized phase against the reference model.
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         bit            r, pu, po, rs;
         int            t;
         logic [KW-1:0] ck;
         r  = ($urandom_range(0, 199) == 0);
         rs = (snaps.size() > 0) && ($urandom_range(0, 9) == 0);
         pu = $urandom_range(0, 1);
         po = $urandom_range(0, 1);
         t  = $urandom_range(1, 4);
         ck = rs ? snaps[$urandom_range(0, snaps.size() - 1)] : KW'(0);
         applyStimulus(r, pu, po, rs, AW'(t), ck);
         model_step(r, pu, po, rs, t, ck);
         checkOutput($sformatf("rand%0d", n), AW'(m_addr[m_ptr]), m_occ != 0,
                     model_ckpt());
         if (r) snaps.delete();
         snaps.push_back(model_ckpt());
         if (snaps.size() > 16) void'(snaps.pop_front());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
